// File: rtl/hex_pkg.sv
// Shared types and constants for the HEX display path.
// The word decoder and the marquee both speak in seg_t.
package hex_pkg;

    // Active-low 7-segment pattern, bit 6..0 = segments 6..0.
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK  = 7'b1111111;
    localparam int   NUM_DIGITS = 6;
    localparam int   RING_LEN   = 7;   // six captured digits plus one blank gap

    // Scroll offset into the ring, 0..RING_LEN-1.
    typedef logic [2:0] off_t;
    localparam off_t OFF_LAST = off_t'(RING_LEN - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SCROLL = 1'b1
    } state_e;

    // Ring position shown on digit k (k = 0 is the leftmost display).
    // Both operands are below RING_LEN, so one conditional subtract
    // replaces a full modulo.
    function automatic off_t ring_idx(input off_t off, input int k);
        int s;
        s = int'(off) + k;
        if (s >= RING_LEN) begin
            s = s - RING_LEN;
        end
        return off_t'(s);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Scroll prescaler: counts 0..TICK_DIV-1 while enabled and emits a
// one-cycle tick during the cycle in which the count sits at TICK_DIV-1.
module tick_gen #(
    parameter int unsigned TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned     CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Tick decode and next count: hold at zero while disabled or cleared.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        tick  = en && (cnt_q == CNT_LAST);
        cnt_d = cnt_q;
        if (clr || !en || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with <= so every flop samples values from
        // before the edge, independent of block evaluation order.
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hex_marquee.sv
// Display stage for the word decoder: captures six segment patterns on
// load and shows them statically or as a left-scrolling marquee with a
// single blank gap. hex5 / leds5 are the leftmost digit.
module hex_marquee
    import hex_pkg::*;
#(
    parameter int unsigned TICK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       scroll_en,
    input  logic [6:0] leds0,
    input  logic [6:0] leds1,
    input  logic [6:0] leds2,
    input  logic [6:0] leds3,
    input  logic [6:0] leds4,
    input  logic [6:0] leds5,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5,
    output logic       step
);

    state_e state_q, state_d;
    seg_t   frame_q [NUM_DIGITS];   // frame_q[0] is the leftmost digit
    seg_t   frame_d [NUM_DIGITS];
    off_t   off_q, off_d;
    logic   step_q, step_d;

    logic   in_scroll;
    logic   cnt_clr;
    logic   tick;

    seg_t   ring [RING_LEN];
    seg_t   disp [NUM_DIGITS];      // disp[i] drives hex<i>

    // The prescaler runs only in SCROLL; a load or a scroll_en drop
    // restarts it so the next step is a full TICK_DIV away.
    assign in_scroll = (state_q == ST_SCROLL);
    assign cnt_clr   = load || (in_scroll && !scroll_en);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (in_scroll),
        .tick  (tick)
    );

    // Next frame / offset / state: load beats scroll_en drop beats tick.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        off_d   = off_q;
        step_d  = 1'b0;

        if (load) begin
            frame_d = '{leds5, leds4, leds3, leds2, leds1, leds0};
            off_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    off_d = '0;
                    if (scroll_en) begin
                        state_d = ST_SCROLL;
                    end
                end
                ST_SCROLL: begin
                    if (!scroll_en) begin
                        state_d = ST_IDLE;
                        off_d   = '0;
                    end else if (tick) begin
                        off_d  = (off_q == OFF_LAST) ? off_t'(0) : off_q + off_t'(1);
                        step_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    off_d   = '0;
                end
            endcase
        end
    end

    // State, frame, offset and step registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            // NOTE: the frame is a small register array, not a RAM, and it is
            // reset on purpose so the displays come up blank rather than
            // showing power-up garbage.
            frame_q <= '{default: SEG_BLANK};
            off_q   <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            off_q   <= off_d;
            step_q  <= step_d;
        end
    end

    // Output mux: digit k from the left shows ring[(off + k) mod 7].
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            ring[i] = frame_q[i];
        end
        ring[RING_LEN-1] = SEG_BLANK;

        disp = '{default: SEG_BLANK};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            disp[NUM_DIGITS-1-k] = ring[ring_idx(off_q, k)];
        end
    end

    assign hex0 = disp[0];
    assign hex1 = disp[1];
    assign hex2 = disp[2];
    assign hex3 = disp[3];
    assign hex4 = disp[4];
    assign hex5 = disp[5];
    assign step = step_q;

endmodule
